obi_ram_arbiter: RTL

Shares the single-port, word-wide testbench RAM between the core's instruction-fetch OBI port and data OBI port inside the test subsystem. Each cycle it grants at most one request and drives the RAM from the winning port. Data has priority, and a consecutive-grant counter keeps instruction fetch from starving. Read data comes back one cycle after grant and is steered to the port that was granted. Addresses outside the RAM window receive an OBI error response and never touch the RAM.

---
 rtl/obi_ram_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/obi_ram_arbiter.sv
// Shares one single-port word-wide RAM between an instruction-fetch OBI port and a data OBI
// port. Data has priority, and a saturating streak counter hands the RAM to instruction fetch
// after MAX_DATA_BURST back-to-back data grants. Read data is returned one cycle after grant
// and is steered to the port that was granted. Out-of-window addresses get an error response
// and never touch the RAM.
module obi_ram_arbiter #(
    parameter int unsigned RAM_ADDR_WIDTH = 22,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // instruction port
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    // data port
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic [31:0]               data_addr_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,
    // RAM port
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic [RAM_ADDR_WIDTH-3:0] ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    input  logic [31:0]               ram_rdata_i
);

    localparam int unsigned StreakW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [StreakW-1:0] MaxBurst = StreakW'(MAX_DATA_BURST);

    logic [StreakW-1:0] streak_q, streak_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_port_q, resp_port_d;  // 0 = instr, 1 = data
    logic               resp_err_q, resp_err_d;

    logic        gnt_instr, gnt_data, gnt_any;
    logic [31:0] win_addr;
    logic        win_in_range;
    logic        resp_live;

    // Grant decision: data first unless instruction fetch has waited out a full burst.
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (!rst_i) begin
            if (data_req_i && (!instr_req_i || streak_q != MaxBurst)) begin
                gnt_data = 1'b1;
            end else if (instr_req_i) begin
                gnt_instr = 1'b1;
            end
        end
    end

    assign gnt_any     = gnt_instr | gnt_data;
    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;

    // Winner address and window check; a shift of 32 or more yields 0, so a full-width
    // window is always in range.
    always_comb begin
        win_addr     = gnt_data ? data_addr_i : instr_addr_i;
        win_in_range = (win_addr >> RAM_ADDR_WIDTH) == 32'd0;
    end

    // RAM drive from the granted port; address and write data are zeroed when not enabled.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        if (gnt_any) begin
            ram_we_o = gnt_data & data_we_i;
            ram_be_o = gnt_data ? data_be_i : 4'hF;
            if (win_in_range) begin
                ram_en_o    = 1'b1;
                ram_addr_o  = win_addr[RAM_ADDR_WIDTH-1:2];
                ram_wdata_o = gnt_data ? data_wdata_i : 32'h0;
            end
        end
    end

    // Next state for the streak counter and the one-deep response pipeline.
    always_comb begin
        streak_d = streak_q;
        if (!instr_req_i || gnt_instr) begin
            streak_d = '0;
        end else if (gnt_data && streak_q != MaxBurst) begin
            streak_d = streak_q + 1'b1;
        end
        resp_valid_d = gnt_any;
        resp_port_d  = gnt_data;
        resp_err_d   = gnt_any & ~win_in_range;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            streak_q     <= streak_d;
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // A response pending when reset rises is dropped, so gate it with rst_i.
    assign resp_live = resp_valid_q & ~rst_i;

    // Response steering; the idle port holds all response outputs at 0.
    always_comb begin
        instr_rvalid_o = resp_live & ~resp_port_q;
        data_rvalid_o  = resp_live & resp_port_q;
        instr_err_o    = instr_rvalid_o & resp_err_q;
        data_err_o     = data_rvalid_o & resp_err_q;
        instr_rdata_o  = (instr_rvalid_o && !resp_err_q) ? ram_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && !resp_err_q) ? ram_rdata_i : 32'h0;
    end

endmodule
